vic_cache_wb: RTL and testbench
===============================

Name: vic_cache_wb

Overview:
- Parametrised, fully associative victim cache with dirty-line writeback.
- Sits between the L1 data cache and the memory arbiter. Holds lines evicted from L1 and returns them on read hits; a read hit removes the entry.
- Dirty entries pushed out by overflow go into an internal writeback FIFO, which drains to memory over a valid/ready handshake. Clean overflow victims are dropped.
- A flush state machine empties the whole victim store, writing back every dirty line.

Parameters:
- DEPTH, 4, number of victim entries (>=2).
- RD_PORTS, 2, number of lookup ports.
- WR_PORTS, 3, number of victim insert ports (<=DEPTH).
- TAG_BITS, 13, line tag width.
- IDX_BITS, 3, set index width.
- DATA_BITS, 64, line data width.
- WB_DEPTH, 4, writeback FIFO depth (>=WR_PORTS).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- wr_valid  in  WR_PORTS  insert request per port.
- wr_tag  in  WR_PORTS x TAG_BITS  victim tag.
- wr_idx  in  WR_PORTS x IDX_BITS  victim set index.
- wr_data  in  WR_PORTS x DATA_BITS  victim data.
- wr_dirty  in  WR_PORTS  victim dirty flag.
- wr_ready  out  1  inserts accepted this cycle.
- rd_en  in  RD_PORTS  lookup enable.
- rd_tag  in  RD_PORTS x TAG_BITS  lookup tag.
- rd_idx  in  RD_PORTS x IDX_BITS  lookup index.
- rd_hit  out  RD_PORTS  combinational hit.
- rd_data  out  RD_PORTS x DATA_BITS  hit data; 0 on miss.
- rd_dirty  out  RD_PORTS  hit entry dirty flag.
- wb_valid  out  1  writeback FIFO non-empty.
- wb_ready  in  1  memory accepts writeback.
- wb_tag  out  TAG_BITS  writeback FIFO head tag.
- wb_idx  out  IDX_BITS  writeback FIFO head index.
- wb_data  out  DATA_BITS  writeback FIFO head data.
- flush_req  in  1  start flush; sampled in IDLE only.
- flush_busy  out  1  FSM not in IDLE.
- flush_done  out  1  one-cycle pulse when the flush completes.
- count  out  $clog2(DEPTH+1)  occupied victim entries.

Behaviour:
- Storage: age-ordered queue; entry 0 is the oldest. Each entry is {valid, dirty, tag, idx, data}. Valid entries are always contiguous from entry 0.
- Reset (reset==0 at posedge):
  - All entries invalid; count=0.
  - Writeback FIFO empty; wb_valid=0; FSM=IDLE.
  - flush_busy=0, flush_done=0, wr_ready=1.
  - rd_hit=0, rd_data=0, rd_dirty=0.
  - Reset overrides everything, including an active flush; the writeback FIFO contents are lost.
- Lookup (combinational on current state):
  - rd_hit[p] = rd_en[p] & an entry is valid and matches {tag,idx}.
  - When the FSM is not IDLE, rd_hit is forced to 0.
  - Every hit entry is removed at the next edge. Survivors compact toward 0 and keep their age order.
  - Two ports hitting the same entry both report the hit; the entry is removed once.
- Insert (IDLE only, when wr_ready=1). Ports are processed in ascending order, after read-hit removal:
  - Tag/idx matches a valid entry: overwrite data in place; dirty = old|new; age unchanged.
  - Otherwise append at the tail.
  - If the queue is full, evict the oldest entry first: a dirty victim is pushed into the writeback FIFO, a clean victim is dropped.
  - A later port matching an earlier same-cycle insert merges with it.
  - A write matching an entry removed by a same-cycle read hit is appended as a new entry.
- wr_ready = (FSM==IDLE) & (WB_DEPTH - fifo_count >= WR_PORTS). fifo_count is the registered value at the start of the cycle. When wr_ready=0, wr_valid is ignored and the sender must hold.
- Writeback FIFO:
  - A pop occurs when wb_valid & wb_ready.
  - Pops and pushes happen in the same cycle; FIFO order is preserved.
  - Pointers wrap modulo WB_DEPTH. The FIFO never overflows, which is guaranteed by wr_ready and the flush stall.
- Flush FSM:
  - IDLE: on flush_req -> FLUSH. Any same-cycle inserts and reads are still processed.
  - FLUSH: each cycle, examine entry 0.
    - Dirty and FIFO not full: push it and remove it.
    - Dirty and FIFO full: stall, no change.
    - Clean: remove it.
    - When count==0 -> DRAIN.
  - DRAIN: when the FIFO is empty -> DONE.
  - DONE: flush_done=1 for one cycle -> IDLE.
  - flush_req outside IDLE is ignored.
- count = number of valid entries, registered.

Test Plan:
- Reset with reset=0 for 2 cycles -> count=0, wb_valid=0, wr_ready=1, flush_busy=0.
- Insert 4 clean lines (tags 1..4, idx 0) over 2 cycles, then rd_en[0] with tag 3 -> rd_hit[0]=1, data matches; next cycle count=3; order is tags 1,2,4.
- Queue full with oldest tag 1 dirty; insert tag 9 -> wb_valid=1, wb_tag=1, count=4; hold wb_ready=0 -> head held until wb_ready=1, then one pop.
- Insert tag 2 dirty=1 while tag 2 is present clean -> no eviction, count unchanged, rd_dirty=1 on a later lookup.
- Fill the FIFO to 2 with wb_ready=0, WB_DEPTH=4, WR_PORTS=3 -> wr_ready=0 and inserts ignored; raise wb_ready -> wr_ready=1 after one pop.
- Queue with 2 dirty and 2 clean entries, pulse flush_req, wb_ready=1 -> flush_busy is high; 2 writebacks in age order; flush_done pulses once; count=0. A repeat with reset=0 asserted mid-FLUSH -> IDLE with everything empty.

Source files
------------

// File: rtl/vic_cache_wb.sv
// Fully associative victim cache with dirty-line writeback FIFO and flush FSM.
module vic_cache_wb #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RD_PORTS  = 2,
  parameter int unsigned WR_PORTS  = 3,
  parameter int unsigned TAG_BITS  = 13,
  parameter int unsigned IDX_BITS  = 3,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned WB_DEPTH  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WR_PORTS-1:0]             wr_valid,
  input  logic [WR_PORTS*TAG_BITS-1:0]    wr_tag,
  input  logic [WR_PORTS*IDX_BITS-1:0]    wr_idx,
  input  logic [WR_PORTS*DATA_BITS-1:0]   wr_data,
  input  logic [WR_PORTS-1:0]             wr_dirty,
  output logic                            wr_ready,
  input  logic [RD_PORTS-1:0]             rd_en,
  input  logic [RD_PORTS*TAG_BITS-1:0]    rd_tag,
  input  logic [RD_PORTS*IDX_BITS-1:0]    rd_idx,
  output logic [RD_PORTS-1:0]             rd_hit,
  output logic [RD_PORTS*DATA_BITS-1:0]   rd_data,
  output logic [RD_PORTS-1:0]             rd_dirty,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [TAG_BITS-1:0]             wb_tag,
  output logic [IDX_BITS-1:0]             wb_idx,
  output logic [DATA_BITS-1:0]            wb_data,
  input  logic                            flush_req,
  output logic                            flush_busy,
  output logic                            flush_done,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned FCW = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic                 dirty;
    logic [TAG_BITS-1:0]  tag;
    logic [IDX_BITS-1:0]  idx;
    logic [DATA_BITS-1:0] data;
  } ent_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [IDX_BITS-1:0]  idx;
    logic [DATA_BITS-1:0] data;
  } wb_t;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_t;

  ent_t          ent_q  [DEPTH];
  ent_t          ent_d  [DEPTH];
  wb_t           fifo_q [WB_DEPTH];
  wb_t           fifo_d [WB_DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  state_t         state_q, state_d;
  logic [DEPTH-1:0] ent_hit;
  logic           pop;
  logic           found;
  int unsigned    n, pushes, fi;
  ent_t           new_e, vic;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == WB_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign wb_valid   = (fcnt_q != '0);
  assign wb_tag     = fifo_q[rptr_q].tag;
  assign wb_idx     = fifo_q[rptr_q].idx;
  assign wb_data    = fifo_q[rptr_q].data;
  assign wr_ready   = (state_q == S_IDLE) && (32'(fcnt_q) + WR_PORTS <= WB_DEPTH);
  assign flush_busy = (state_q != S_IDLE);
  assign flush_done = (state_q == S_DONE);
  assign count      = cnt_q;

  // Associative lookup on every port; only valid in IDLE
  always_comb begin
    rd_hit   = '0;
    rd_data  = '0;
    rd_dirty = '0;
    ent_hit  = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (state_q == S_IDLE && rd_en[p] && CW'(i) < cnt_q &&
            ent_q[i].tag == rd_tag[p*TAG_BITS +: TAG_BITS] &&
            ent_q[i].idx == rd_idx[p*IDX_BITS +: IDX_BITS]) begin
          rd_hit[p]                         = 1'b1;
          rd_data[p*DATA_BITS +: DATA_BITS] = ent_q[i].data;
          rd_dirty[p]                       = ent_q[i].dirty;
          ent_hit[i]                        = 1'b1;
        end
      end
    end
  end

  // Next state: hit removal, in-order inserts with eviction, flush walk, FIFO pointers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ent_d   = ent_q;
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    n       = 0;
    pushes  = 0;
    found   = 1'b0;
    fi      = 0;
    new_e   = '0;
    vic     = '0;
    pop     = wb_valid && wb_ready;
    if (pop) rptr_d = ptr_inc(rptr_q);
    unique case (state_q)
      S_IDLE: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) < cnt_q && !ent_hit[i]) begin
            ent_d[AW'(n)] = ent_q[i];
            n = n + 1;
          end
        end
        if (wr_ready) begin
          for (int unsigned w = 0; w < WR_PORTS; w++) begin
            if (wr_valid[w]) begin
              new_e.dirty = wr_dirty[w];
              new_e.tag   = wr_tag[w*TAG_BITS +: TAG_BITS];
              new_e.idx   = wr_idx[w*IDX_BITS +: IDX_BITS];
              new_e.data  = wr_data[w*DATA_BITS +: DATA_BITS];
              found = 1'b0;
              fi    = 0;
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i < n && ent_d[i].tag == new_e.tag && ent_d[i].idx == new_e.idx) begin
                  found = 1'b1;
                  fi    = i;
                end
              end
              if (found) begin
                ent_d[AW'(fi)].data  = new_e.data;
                ent_d[AW'(fi)].dirty = ent_d[AW'(fi)].dirty | new_e.dirty;
              end else begin
                if (n == DEPTH) begin
                  vic = ent_d[0];
                  if (vic.dirty) begin
                    fifo_d[wptr_d] = '{tag: vic.tag, idx: vic.idx, data: vic.data};
                    wptr_d = ptr_inc(wptr_d);
                    pushes = pushes + 1;
                  end
                  for (int unsigned i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_d[i+1];
                  n = n - 1;
                end
                ent_d[AW'(n)] = new_e;
                n = n + 1;
              end
            end
          end
        end
        cnt_d = CW'(n);
        if (flush_req) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
        end else if (!(ent_q[0].dirty && 32'(fcnt_q) == WB_DEPTH)) begin
          vic = ent_q[0];
          if (vic.dirty) begin
            fifo_d[wptr_d] = '{tag: vic.tag, idx: vic.idx, data: vic.data};
            wptr_d = ptr_inc(wptr_d);
            pushes = pushes + 1;
          end
          for (int unsigned i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DRAIN: begin
        if (fcnt_q == '0) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    fcnt_d = FCW'(32'(fcnt_q) + pushes - 32'(pop));
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Line and FIFO payload storage, qualified by cnt_q / fcnt_q
  always_ff @(posedge clock) begin
    ent_q  <= ent_d;
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_vic_cache_wb.sv
// Bench for vic_cache_wb: queue-based reference model plus directed literal checks.
module tb_vic_cache_wb;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RDP   = 2;
  localparam int unsigned WRP   = 3;
  localparam int unsigned TB    = 13;
  localparam int unsigned IB    = 3;
  localparam int unsigned DB    = 64;
  localparam int unsigned WBD   = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic [WRP-1:0]    wr_valid;
  logic [WRP*TB-1:0] wr_tag;
  logic [WRP*IB-1:0] wr_idx;
  logic [WRP*DB-1:0] wr_data;
  logic [WRP-1:0]    wr_dirty;
  logic              wr_ready;
  logic [RDP-1:0]    rd_en;
  logic [RDP*TB-1:0] rd_tag;
  logic [RDP*IB-1:0] rd_idx;
  logic [RDP-1:0]    rd_hit;
  logic [RDP*DB-1:0] rd_data;
  logic [RDP-1:0]    rd_dirty;
  logic              wb_valid;
  logic              wb_ready;
  logic [TB-1:0]     wb_tag;
  logic [IB-1:0]     wb_idx;
  logic [DB-1:0]     wb_data;
  logic              flush_req;
  logic              flush_busy;
  logic              flush_done;
  logic [CW-1:0]     count;

  vic_cache_wb #(.DEPTH(DEPTH), .RD_PORTS(RDP), .WR_PORTS(WRP), .TAG_BITS(TB),
                 .IDX_BITS(IB), .DATA_BITS(DB), .WB_DEPTH(WBD)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_tag(wr_tag), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_dirty(wr_dirty), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_idx(rd_idx),
    .rd_hit(rd_hit), .rd_data(rd_data), .rd_dirty(rd_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_idx(wb_idx),
    .wb_data(wb_data), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .count(count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DB-1:0] dat(input int t);
    return 64'hA5A5_0000_0000_0000 | 64'(t);
  endfunction

  // Reference model: age-ordered line queue, writeback queue, flush phase
  typedef struct {
    logic          dirty;
    logic [TB-1:0] tag;
    logic [IB-1:0] idx;
    logic [DB-1:0] data;
  } ment_t;

  ment_t m_q[$];
  ment_t m_wb[$];
  int    m_mode = 0;   // 0 idle, 1 flushing lines, 2 draining, 3 done pulse
  int    start;
  bit    rdy, hit, any, merged;
  ment_t e, v;
  logic [DB-1:0] ed;
  logic eh, edt;

  always @(negedge clock) begin
    if (chk_en) begin
      rdy = (m_mode == 0) && (WBD - m_wb.size() >= WRP);
      chk("count", 64'(count), 64'(m_q.size()));
      chk("wb_valid", 64'(wb_valid), 64'(m_wb.size() != 0));
      if (m_wb.size() != 0) begin
        chk("wb_tag", 64'(wb_tag), 64'(m_wb[0].tag));
        chk("wb_idx", 64'(wb_idx), 64'(m_wb[0].idx));
        chk("wb_data", 64'(wb_data), 64'(m_wb[0].data));
      end
      chk("wr_ready", 64'(wr_ready), 64'(rdy));
      chk("flush_busy", 64'(flush_busy), 64'(m_mode != 0));
      chk("flush_done", 64'(flush_done), 64'(m_mode == 3));
      for (int p = 0; p < RDP; p++) begin
        eh = 1'b0; ed = '0; edt = 1'b0;
        if (m_mode == 0 && rd_en[p]) begin
          foreach (m_q[i]) begin
            if (m_q[i].tag == rd_tag[p*TB +: TB] && m_q[i].idx == rd_idx[p*IB +: IB]) begin
              eh = 1'b1; ed = m_q[i].data; edt = m_q[i].dirty;
            end
          end
        end
        chk("rd_hit", 64'(rd_hit[p]), 64'(eh));
        chk("rd_data", 64'(rd_data[p*DB +: DB]), 64'(ed));
        chk("rd_dirty", 64'(rd_dirty[p]), 64'(edt));
      end
      // advance the model to the state after this edge
      if (!reset) begin
        m_q.delete(); m_wb.delete(); m_mode = 0;
      end else begin
        start = m_wb.size();
        if (start > 0 && wb_ready) void'(m_wb.pop_front());
        case (m_mode)
          0: begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
              any = 1'b0;
              for (int p = 0; p < RDP; p++)
                if (rd_en[p] && m_q[i].tag == rd_tag[p*TB +: TB] && m_q[i].idx == rd_idx[p*IB +: IB])
                  any = 1'b1;
              if (any) m_q.delete(i);
            end
            if (rdy) begin
              for (int w = 0; w < WRP; w++) begin
                if (wr_valid[w]) begin
                  e.dirty = wr_dirty[w]; e.tag = wr_tag[w*TB +: TB];
                  e.idx = wr_idx[w*IB +: IB]; e.data = wr_data[w*DB +: DB];
                  merged = 1'b0;
                  foreach (m_q[i]) begin
                    if (m_q[i].tag == e.tag && m_q[i].idx == e.idx) begin
                      m_q[i].data = e.data; m_q[i].dirty = m_q[i].dirty | e.dirty; merged = 1'b1;
                    end
                  end
                  if (!merged) begin
                    if (m_q.size() == DEPTH) begin
                      v = m_q.pop_front();
                      if (v.dirty) m_wb.push_back(v);
                    end
                    m_q.push_back(e);
                  end
                end
              end
            end
            if (flush_req) m_mode = 1;
          end
          1: begin
            if (m_q.size() == 0) m_mode = 2;
            else if (!(m_q[0].dirty && start == WBD)) begin
              v = m_q.pop_front();
              if (v.dirty) m_wb.push_back(v);
            end
          end
          2: if (start == 0) m_mode = 3;
          default: m_mode = 0;
        endcase
      end
    end
  end

  // Observed writeback tags and done pulses, for hand-computed checks
  int pops[$];
  int ndone = 0;
  always @(negedge clock) begin
    if (chk_en && reset) begin
      if (wb_valid && wb_ready) pops.push_back(int'(wb_tag));
      if (flush_done) ndone++;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    wr_valid = '0; rd_en = '0; flush_req = 1'b0;
  endtask

  task automatic set_wr(input int p, input int t, input bit d);
    wr_valid[p] = 1'b1;
    wr_tag[p*TB +: TB] = TB'(t);
    wr_idx[p*IB +: IB] = '0;
    wr_data[p*DB +: DB] = dat(t);
    wr_dirty[p] = d;
  endtask

  task automatic set_rd(input int p, input int t);
    rd_en[p] = 1'b1;
    rd_tag[p*TB +: TB] = TB'(t);
    rd_idx[p*IB +: IB] = '0;
  endtask

  initial begin
    reset = 1'b0; wb_ready = 1'b0;
    wr_tag = '0; wr_idx = '0; wr_data = '0; wr_dirty = '0;
    rd_tag = '0; rd_idx = '0;
    clr();
    cyc(); cyc();
    reset = 1'b1; chk_en = 1'b1;
    set_rd(0, 5);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_busy", 64'(flush_busy), 64'd0);
    chk("rst_rd_hit", 64'(rd_hit), 64'd0);
    chk("rst_rd_data", 64'(rd_data[DB-1:0]), 64'd0);
    clr();

    // four clean lines, then a read hit on tag 3
    set_wr(0, 1, 0); set_wr(1, 2, 0); set_wr(2, 3, 0);
    cyc(); clr(); set_wr(0, 4, 0);
    cyc(); clr(); set_rd(0, 3);
    #1;
    chk("hit3", 64'(rd_hit[0]), 64'd1);
    chk("hit3_data", 64'(rd_data[DB-1:0]), 64'hA5A5_0000_0000_0003);
    chk("count4", 64'(count), 64'd4);
    cyc(); clr();
    #1 chk("count3", 64'(count), 64'd3);

    // tag 1 made dirty in place, fill, then overflow evicts it
    set_wr(0, 1, 1);
    cyc(); clr(); set_wr(0, 5, 0);
    cyc(); clr(); set_wr(0, 9, 0);
    cyc(); clr();
    #1;
    chk("evict_valid", 64'(wb_valid), 64'd1);
    chk("evict_tag", 64'(wb_tag), 64'd1);
    chk("evict_data", 64'(wb_data), 64'hA5A5_0000_0000_0001);
    chk("evict_count", 64'(count), 64'd4);
    cyc(); cyc();
    chk("hold_tag", 64'(wb_tag), 64'd1);
    wb_ready = 1'b1;
    cyc(); wb_ready = 1'b0;
    #1 chk("popped", 64'(wb_valid), 64'd0);

    // dirty merge onto clean tag 2: no eviction
    set_wr(0, 2, 1);
    cyc(); clr();
    #1;
    chk("merge_count", 64'(count), 64'd4);
    chk("merge_novict", 64'(wb_valid), 64'd0);
    set_rd(1, 2);
    #1 chk("merge_dirty", 64'(rd_dirty[1]), 64'd1);
    cyc(); clr();

    // fill writeback FIFO to 2 with memory stalled
    set_wr(0, 10, 1); set_wr(1, 11, 1); set_wr(2, 12, 1);
    cyc(); clr(); set_wr(0, 13, 1); set_wr(1, 14, 1);
    cyc(); clr(); set_wr(0, 15, 0);
    cyc(); clr();
    #1;
    chk("full_ready", 64'(wr_ready), 64'd0);
    chk("full_head", 64'(wb_tag), 64'd10);
    set_wr(0, 16, 0);
    cyc(); cyc();
    chk("ignored_count", 64'(count), 64'd4);
    chk("ignored_head", 64'(wb_tag), 64'd10);
    wb_ready = 1'b1;
    #1 chk("still_blocked", 64'(wr_ready), 64'd0);
    cyc();
    chk("ready_again", 64'(wr_ready), 64'd1);
    chk("next_head", 64'(wb_tag), 64'd11);
    cyc(); clr();
    cyc(); cyc();
    chk("drained", 64'(wb_valid), 64'd0);
    pops.delete(); ndone = 0;

    // flush: 13d,14d,15c,16c
    flush_req = 1'b1;
    cyc(); flush_req = 1'b0;
    #1 chk("busy", 64'(flush_busy), 64'd1);
    for (int k = 0; k < 40; k++) begin
      if (flush_done) break;
      cyc();
    end
    chk("done_seen", 64'(flush_done), 64'd1);
    cyc();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_idle", 64'(flush_busy), 64'd0);
    chk("done_pulses", 64'(ndone), 64'd1);
    chk("wb_pops", 64'(pops.size()), 64'd2);
    if (pops.size() == 2) begin
      chk("wb_first", 64'(pops[0]), 64'd13);
      chk("wb_second", 64'(pops[1]), 64'd14);
    end

    // reset in the middle of a flush
    wb_ready = 1'b0;
    set_wr(0, 30, 1); set_wr(1, 31, 1); set_wr(2, 32, 1);
    cyc(); clr(); set_wr(0, 33, 1);
    cyc(); clr(); flush_req = 1'b1;
    cyc(); flush_req = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); reset = 1'b1;
    #1;
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_wb_valid", 64'(wb_valid), 64'd0);
    chk("mid_busy", 64'(flush_busy), 64'd0);
    chk("mid_ready", 64'(wr_ready), 64'd1);

    // dual-port hit on one entry, then read+write of the same line
    set_wr(0, 40, 0); set_wr(1, 41, 0);
    cyc(); clr(); set_rd(0, 40); set_rd(1, 40);
    #1 chk("dual_hit", 64'(rd_hit), 64'd3);
    cyc(); clr();
    #1 chk("dual_count", 64'(count), 64'd1);
    set_rd(0, 41); set_wr(0, 41, 1);
    #1 chk("rw_hit_clean", 64'(rd_dirty[0]), 64'd0);
    cyc(); clr();
    #1 chk("rw_count", 64'(count), 64'd1);
    set_rd(0, 41);
    #1;
    chk("rw_new_dirty", 64'(rd_dirty[0]), 64'd1);
    chk("rw_new_data", 64'(rd_data[DB-1:0]), 64'hA5A5_0000_0000_0029);
    cyc(); clr();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
